// File: rtl/div_pkg.sv
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the run-time clock divider
//                controller (FSM state encoding, minimum legal ratio).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package div_pkg;

  // Controller states.
  //   IDLE : divider stopped, outputs low, ratio may be loaded directly
  //   RUN  : dividing with the active ratio, no ratio waiting
  //   PEND : dividing, a new ratio waits for the next period boundary
  //   STOP : enable dropped, finishing the current period before idling
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } div_state_e;

  // Smallest ratio that yields a real divided clock.
  localparam int unsigned MIN_DIV = 2;

endpackage : div_pkg

`default_nettype wire

// File: rtl/div_cnt_core.sv
// ============================================================================
//  Module      : div_cnt_core
//  Description : Period counter of the clock divider. Counts 0..ratio-1 and
//                produces the registered divided clock and period tick.
//                div_out/tick are loaded from the next counter value so they
//                line up with the counter.
//  Ports       : clk, reset       - system clock, sync active-high reset
//                restart          - force counter to 0 and start a period
//                clear            - force counter to 0 with outputs low
//                ratio_cur        - ratio of the period in progress
//                ratio_next       - ratio in effect from the next cycle on
//                wrap             - counter is on the last cycle of a period
//                div_out, tick    - divided clock, first-cycle-of-period pulse
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_cnt_core #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             clear,
  input  logic [CNT_W-1:0] ratio_cur,
  input  logic [CNT_W-1:0] ratio_next,
  output logic             wrap,
  output logic             div_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
  localparam logic [CNT_W:0]   C_ONE_WIDE = (CNT_W + 1)'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_out_q, div_out_d;
  logic             tick_q, tick_d;
  logic [CNT_W:0]   half_next;

  always_comb begin
    wrap      = (cnt_q == ratio_cur - C_ONE);
    // High phase length H = ceil(ratio/2); one extra bit keeps the +1 exact.
    half_next = ({1'b0, ratio_next} + C_ONE_WIDE) >> 1;

    cnt_d = cnt_q + C_ONE;
    if (clear || restart || wrap) begin
      cnt_d = '0;
    end

    div_out_d = !clear && ({1'b0, cnt_d} < half_next);
    tick_d    = !clear && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      div_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_out_q <= div_out_d;
      tick_q    <= tick_d;
    end
  end

  assign div_out = div_out_q;
  assign tick    = tick_q;

endmodule : div_cnt_core

`default_nettype wire

// File: rtl/div_ratio_ctrl.sv
// ============================================================================
//  Module      : div_ratio_ctrl
//  Description : Run-time controller for the counter-based clock divider.
//                Holds the active ratio, accepts new ratios over valid/ready
//                and applies them only at a period boundary so div_out never
//                produces a runt pulse.
//  Ports       : clk, reset   - system clock, sync active-high reset
//                enable       - run divider / stop at next period boundary
//                cfg_valid    - new ratio offered
//                cfg_div      - requested ratio (legal: >= 2)
//                cfg_ready    - ratio can be accepted this cycle
//                cfg_err      - one-cycle pulse: accepted ratio was illegal
//                div_out      - divided clock (registered)
//                tick         - one-cycle pulse at the start of each period
//                busy         - controller is not idle
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_ratio_ctrl
  import div_pkg::*;
#(
  parameter int CNT_W       = 11,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             div_out,
  output logic             tick,
  output logic             busy
);

  localparam logic [CNT_W-1:0] C_DEF_RATIO = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] C_MIN_RATIO = CNT_W'(MIN_DIV);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             pend_vld_q, pend_vld_d;
  logic             cfg_err_q, cfg_err_d;

  logic             xfer;
  logic             take;
  logic             wrap;
  logic             restart;
  logic             clear;

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    pending_d  = pending_q;
    pend_vld_d = pend_vld_q;
    restart    = 1'b0;
    clear      = 1'b0;

    cfg_ready  = (state_q == IDLE) || (state_q == RUN);
    xfer       = cfg_valid && cfg_ready;
    take       = xfer && (cfg_div >= C_MIN_RATIO);
    cfg_err_d  = xfer && !take;

    case (state_q)
      IDLE: begin
        if (take) begin
          active_d = cfg_div;
        end
        if (enable) begin
          restart = 1'b1;
          state_d = RUN;
        end else begin
          clear = 1'b1;
        end
      end

      default: begin
        // RUN, PEND and STOP all keep counting; they differ only in whether a
        // ratio is waiting (pend_vld_q) and whether enable is still high.
        if (take) begin
          pending_d  = cfg_div;
          pend_vld_d = 1'b1;
        end

        if (wrap) begin
          // Period boundary: a waiting ratio becomes active now. A ratio
          // accepted on this very cycle (only possible from RUN, where nothing
          // was waiting) waits for the following boundary.
          if (pend_vld_q) begin
            active_d = pending_q;
          end
          pend_vld_d = take;

          if (!enable) begin
            // Stopping: nothing more to wait for, so a ratio taken on the
            // final edge is applied directly.
            clear      = 1'b1;
            state_d    = IDLE;
            pend_vld_d = 1'b0;
            if (take) begin
              active_d = cfg_div;
            end
          end else begin
            state_d = take ? PEND : RUN;
          end
        end else if (!enable) begin
          state_d = STOP;
        end else begin
          state_d = pend_vld_d ? PEND : RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      active_q   <= C_DEF_RATIO;
      pending_q  <= '0;
      pend_vld_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      pend_vld_q <= pend_vld_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  div_cnt_core #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .restart    (restart),
    .clear      (clear),
    .ratio_cur  (active_q),
    .ratio_next (active_d),
    .wrap       (wrap),
    .div_out    (div_out),
    .tick       (tick)
  );

  assign cfg_err = cfg_err_q;
  assign busy    = (state_q != IDLE);

endmodule : div_ratio_ctrl

`default_nettype wire

// File: tb/tb_div_ratio_ctrl.sv
// ============================================================================
//  Module      : tb_div_ratio_ctrl
//  Description : Self-checking bench for div_ratio_ctrl: directed scenarios
//                followed by randomized traffic, all compared cycle by cycle
//                against a behavioural model of the divider.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_ratio_ctrl;

  localparam int CNT_W       = 11;
  localparam int DEFAULT_DIV = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             div_out;
  logic             tick;
  logic             busy;

  div_ratio_ctrl #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .div_out   (div_out),
    .tick      (tick),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: running/stopping flags, ratio numbers, position in
  // period, and -1 meaning "no ratio waiting".
  bit m_run, m_stop, m_err;
  int m_act, m_pend, m_pos;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return !m_run || (!m_stop && m_pend < 0);
  endfunction

  task automatic check_outs();
    chk("div_out", div_out, (m_run && m_pos < (m_act + 1) / 2) ? 1 : 0);
    chk("tick",    tick,    (m_run && m_pos == 0) ? 1 : 0);
    chk("busy",    busy,    m_run ? 1 : 0);
    chk("cfg_err", cfg_err, m_err ? 1 : 0);
    chk("cfg_ready", cfg_ready, m_ready() ? 1 : 0);
  endtask

  task automatic model_reset();
    m_run = 0; m_stop = 0; m_err = 0;
    m_act = DEFAULT_DIV; m_pend = -1; m_pos = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    model_reset();
    check_outs();
    reset = 1'b0;
  endtask

  // One clock: apply inputs at the falling edge, advance the model across the
  // rising edge, compare at the next falling edge.
  task automatic cycle(input bit en, input bit v, input int d);
    bit ready, take;
    int n_act, n_pend, n_pos;
    bit n_run, n_stop;
    enable = en; cfg_valid = v; cfg_div = d[CNT_W-1:0];
    ready  = m_ready();
    take   = v && ready && d >= 2;
    n_act = m_act; n_pend = m_pend; n_pos = m_pos; n_run = m_run; n_stop = m_stop;
    m_err = v && ready && d < 2;
    if (!m_run) begin
      if (take) n_act = d;
      if (en) begin n_run = 1; n_pos = 0; end
    end else if (m_pos == m_act - 1) begin
      if (m_pend >= 0) n_act = m_pend;
      n_pend = take ? d : -1;
      n_pos  = 0;
      n_stop = 0;
      if (!en) begin
        n_run  = 0;
        n_pend = -1;
        if (take) n_act = d;
      end
    end else begin
      n_pos = m_pos + 1;
      if (take) n_pend = d;
      n_stop = !en;
    end
    @(posedge clk);
    m_act = n_act; m_pend = n_pend; m_pos = n_pos; m_run = n_run; m_stop = n_stop;
    @(negedge clk);
    check_outs();
  endtask

  logic [7:0] pat_div, pat_tick;
  int d;

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    @(negedge clk);

    // Reset state.
    do_reset(3);

    // Ratio 4 loaded while idle, then run: 1,1,0,0 with a tick every 4th.
    cycle(0, 1, 4);
    pat_div = '0; pat_tick = '0;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 0);
      pat_div  = {pat_div[6:0], div_out};
      pat_tick = {pat_tick[6:0], tick};
    end
    chk("n4_div_pattern",  pat_div,  8'b1100_1100);
    chk("n4_tick_pattern", pat_tick, 8'b1000_1000);

    // Ratio change mid-period (position 1): held off until the boundary.
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 1, 6);
    chk("pend_not_ready", cfg_ready, 1'b0);
    repeat (14) cycle(1, 0, 0);

    // Illegal ratio: error pulse, period unchanged.
    cycle(1, 1, 1);
    chk("err_pulse", cfg_err, 1'b1);
    cycle(1, 0, 0);
    chk("err_one_cycle", cfg_err, 1'b0);
    repeat (8) cycle(1, 0, 0);

    // Stop, load odd ratio 5, run: 3 high / 2 low.
    repeat (8) cycle(0, 0, 0);
    chk("stopped_idle", busy, 1'b0);
    cycle(0, 1, 5);
    pat_div = '0;
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0);
      pat_div = {pat_div[6:0], div_out};
    end
    chk("n5_div_pattern", pat_div[4:0], 5'b11100);
    repeat (5) cycle(1, 0, 0);

    // Ratio 4, drop enable at position 1: period completes, then idle.
    repeat (6) cycle(0, 0, 0);
    cycle(0, 1, 4);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("stop_still_busy", busy, 1'b1);
    cycle(0, 0, 0);
    chk("stop_idle_after_wrap", busy, 1'b0);

    // Reset while a ratio is pending: next run uses the default ratio.
    cycle(1, 0, 0);
    cycle(1, 1, 7);
    do_reset(1);
    repeat (6) cycle(1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        d = ($urandom_range(0, 15) == 0) ? int'($urandom_range(2, 40)) : int'($urandom_range(0, 9));
        cycle($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_div_ratio_ctrl

`default_nettype wire
